// File: rtl/snitch_tcdm_width_adapter.sv
// Narrow-to-wide TCDM adapter: places narrow requests on their lane of the wide port
// and keeps an in-order FIFO of lane offsets so each response is taken from the right lane.
package snitch_tcdm_width_adapter_pkg;
    typedef struct packed {
        logic [47:0]  addr;
        logic         write;
        logic [3:0]   amo;
        logic [511:0] data;
        logic [63:0]  strb;
        logic         user;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_t;

    typedef struct packed {
        logic [511:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        tcdm_rsp_chan_t p;
        logic           p_valid;
        logic           q_ready;
    } tcdm_rsp_t;
endpackage

module snitch_tcdm_width_adapter #(
    parameter type         tcdm_req_t     = snitch_tcdm_width_adapter_pkg::tcdm_req_t,
    parameter type         tcdm_rsp_t     = snitch_tcdm_width_adapter_pkg::tcdm_rsp_t,
    parameter int unsigned DataWidth      = 512,
    parameter int unsigned TCDMDataWidth  = 64,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  tcdm_req_t tcdm_req_narrow_i,
    output tcdm_rsp_t tcdm_rsp_narrow_o,
    output tcdm_req_t tcdm_req_wide_o,
    input  tcdm_rsp_t tcdm_rsp_wide_i
);

    localparam int unsigned NumLanes   = DataWidth / TCDMDataWidth;
    localparam int unsigned OffW       = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam int unsigned WideOffW   = $clog2(DataWidth / 8);
    localparam int unsigned NarrowOffW = $clog2(TCDMDataWidth / 8);
    localparam int unsigned StrbW      = DataWidth / 8;
    localparam int unsigned NStrbW     = TCDMDataWidth / 8;
    localparam int unsigned PtrW       = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW       = $clog2(MaxOutstanding + 1);

    logic [OffW-1:0] fifo_q [MaxOutstanding];
    logic [OffW-1:0] fifo_d [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [AddrWidth-1:0] narrow_addr;
    logic [AddrWidth-1:0] wide_addr;
    logic [OffW-1:0]      off;
    logic [OffW-1:0]      head_off;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [DataWidth-1:0] rsp_shifted;

    assign narrow_addr = tcdm_req_narrow_i.q.addr;

    if (NumLanes > 1) begin : g_lane_off
        assign off = narrow_addr[WideOffW-1:NarrowOffW];
    end else begin : g_single_lane
        assign off = '0;
    end

    assign full     = (count_q == CntW'(MaxOutstanding));
    assign head_off = fifo_q[rptr_q];
    assign push     = tcdm_req_wide_o.q_valid & tcdm_rsp_wide_i.q_ready;
    // p_valid with an empty FIFO still passes data, but must not underflow the bookkeeping.
    assign pop      = tcdm_rsp_wide_i.p_valid & (count_q != '0);

    always_comb begin
        wide_addr                 = narrow_addr;
        wide_addr[WideOffW-1:0]   = '0;
        tcdm_req_wide_o           = tcdm_req_narrow_i;
        tcdm_req_wide_o.q.addr    = wide_addr;
        tcdm_req_wide_o.q.data    = DataWidth'(tcdm_req_narrow_i.q.data[TCDMDataWidth-1:0])
                                    << (off * TCDMDataWidth);
        tcdm_req_wide_o.q.strb    = StrbW'(tcdm_req_narrow_i.q.strb[NStrbW-1:0])
                                    << (off * NStrbW);
        tcdm_req_wide_o.q_valid   = tcdm_req_narrow_i.q_valid & ~full;
    end

    always_comb begin
        rsp_shifted                 = tcdm_rsp_wide_i.p.data >> (head_off * TCDMDataWidth);
        tcdm_rsp_narrow_o           = '0;
        tcdm_rsp_narrow_o.p.data    = DataWidth'(rsp_shifted[TCDMDataWidth-1:0]);
        tcdm_rsp_narrow_o.p_valid   = tcdm_rsp_wide_i.p_valid;
        tcdm_rsp_narrow_o.q_ready   = tcdm_rsp_wide_i.q_ready & ~full;
    end

    always_comb begin
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            fifo_d[wptr_q] = off;
            wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            fifo_q  <= '{default: '0};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end

    rsp_without_request: assert property (
        @(posedge clk_i) disable iff (rst_i) tcdm_rsp_wide_i.p_valid |-> (count_q != '0)
    );

endmodule

// File: tb/tb_snitch_tcdm_width_adapter.sv
// Self-checking bench for snitch_tcdm_width_adapter: vector table for request alignment,
// scoreboard of expected lane data for responses, hand sequences for full/reset cases.
module tb_snitch_tcdm_width_adapter;
    import snitch_tcdm_width_adapter_pkg::*;

    logic      clk;
    logic      rst;
    tcdm_req_t req_n;
    tcdm_rsp_t rsp_n;
    tcdm_req_t req_w;
    tcdm_rsp_t rsp_w;

    snitch_tcdm_width_adapter #(
        .tcdm_req_t     (tcdm_req_t),
        .tcdm_rsp_t     (tcdm_rsp_t),
        .DataWidth      (512),
        .TCDMDataWidth  (64),
        .AddrWidth      (48),
        .MaxOutstanding (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .tcdm_req_narrow_i (req_n),
        .tcdm_rsp_narrow_o (rsp_n),
        .tcdm_req_wide_o   (req_w),
        .tcdm_rsp_wide_i   (rsp_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned  due;
        logic [511:0] data;
    } pend_t;

    typedef struct {
        logic [47:0] addr;
        bit          write;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [47:0] exp_waddr;
        int unsigned exp_lane;
    } vec_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned id_ctr = 0;
    tcdm_req_t   s_req_w;
    tcdm_rsp_t   s_rsp_n;
    vec_t        vecs[7];

    function automatic logic [63:0] lane_val(input int unsigned id, input logic [2:0] k);
        if (id == 0 && k == 3'd3) return 64'hDEADBEEF_CAFEF00D;
        return {5'd0, k, 24'hA5A5A5, id[31:0]};
    endfunction

    function automatic logic [511:0] wide_word(input int unsigned id);
        logic [511:0] w;
        for (int k = 0; k < 8; k++) w[k*64 +: 64] = lane_val(id, 3'(k));
        return w;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input bit v, input logic [47:0] a, input bit w,
                        input logic [63:0] d, input logic [7:0] s);
        pend_t       pe;
        logic [63:0] e;
        req_n           = '0;
        req_n.q_valid   = v;
        req_n.q.addr    = a;
        req_n.q.write   = w;
        req_n.q.data    = 512'(d);
        req_n.q.strb    = 64'(s);
        rsp_w.p_valid   = 1'b0;
        rsp_w.p.data    = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            pe            = pend.pop_front();
            rsp_w.p_valid = 1'b1;
            rsp_w.p.data  = pe.data;
        end
        #4;
        s_req_w = req_w;
        s_rsp_n = rsp_n;
        if (rsp_w.p_valid) begin
            chk("rsp_valid", 512'(rsp_n.p_valid), 512'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got response with empty scoreboard");
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_n.p.data, 512'(e));
            end
        end
        if (v && req_w.q_valid && rsp_w.q_ready) begin
            pe.due  = cyc + lat;
            pe.data = wide_word(id_ctr);
            pend.push_back(pe);
            exp_q.push_back(lane_val(id_ctr, a[5:3]));
            id_ctr++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < pend.size(); i++) pend[i].due = cyc + i;
        for (int i = 0; i < 32 && pend.size() > 0; i++) tick(0, '0, 0, '0, '0);
        chk("drain_pending", 512'(pend.size()), 512'd0);
        chk("drain_scoreboard", 512'(exp_q.size()), 512'd0);
    endtask

    initial begin
        vecs[0] = '{48'h1018,         0, 64'h0123456789ABCDEF, 8'hFF, 48'h1000,         3};
        vecs[1] = '{48'h38,           1, 64'h1122334455667788, 8'hFF, 48'h0,            7};
        vecs[2] = '{48'h2FC8,         1, 64'h00000000CAFEBABE, 8'h0F, 48'h2FC0,         1};
        vecs[3] = '{48'hABCDE0,       0, 64'h5555AAAA5555AAAA, 8'hF0, 48'hABCDC0,       4};
        vecs[4] = '{48'hFFFFFFFFFFF8, 0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 48'hFFFFFFFFFFC0, 7};
        vecs[5] = '{48'h40,           1, 64'h8000000000000001, 8'h81, 48'h40,           0};
        vecs[6] = '{48'h1F,           0, 64'h00000000000000AA, 8'h01, 48'h0,            3};

        // Pass-through behaviour while held in reset.
        rst           = 1'b1;
        req_n         = '0;
        rsp_w         = '0;
        rsp_w.q_ready = 1'b1;
        #2;
        req_n.q_valid = 1'b1;
        #1;
        chk("rst_wvalid", 512'(req_w.q_valid), 512'd1);
        chk("rst_qready_hi", 512'(rsp_n.q_ready), 512'd1);
        rsp_w.q_ready = 1'b0;
        #1;
        chk("rst_qready_lo", 512'(rsp_n.q_ready), 512'd0);
        rsp_w.q_ready = 1'b1;
        rsp_w.p_valid = 1'b1;
        #1;
        chk("rst_pvalid", 512'(rsp_n.p_valid), 512'd1);
        rsp_w.p_valid = 1'b0;
        req_n.q_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read, response one cycle later.
        lat = 1;
        tick(1, 48'h1018, 0, '0, '0);
        chk("single_waddr", 512'(s_req_w.q.addr), 512'h1000);
        tick(0, '0, 0, '0, '0);
        chk("single_rdata", s_rsp_n.p.data, 512'hDEADBEEF_CAFEF00D);

        // Request alignment table, each response one cycle later.
        foreach (vecs[i]) begin
            tick(1, vecs[i].addr, vecs[i].write, vecs[i].data, vecs[i].strb);
            chk("tbl_wvalid", 512'(s_req_w.q_valid), 512'd1);
            chk("tbl_qready", 512'(s_rsp_n.q_ready), 512'd1);
            chk("tbl_waddr", 512'(s_req_w.q.addr), 512'(vecs[i].exp_waddr));
            chk("tbl_write", 512'(s_req_w.q.write), 512'(vecs[i].write));
            chk("tbl_wdata", s_req_w.q.data, 512'(vecs[i].data) << (vecs[i].exp_lane * 64));
            chk("tbl_wstrb", 512'(s_req_w.q.strb), 512'(64'(vecs[i].strb) << (vecs[i].exp_lane * 8)));
        end
        drain();

        // Pipelined reads at lanes 1,5,2,7 with three-cycle responses.
        lat = 3;
        tick(1, 48'h2008, 0, '0, '0); chk("pipe_qready0", 512'(s_rsp_n.q_ready), 512'd1);
        tick(1, 48'h2028, 0, '0, '0); chk("pipe_qready1", 512'(s_rsp_n.q_ready), 512'd1);
        tick(1, 48'h2010, 0, '0, '0); chk("pipe_qready2", 512'(s_rsp_n.q_ready), 512'd1);
        tick(1, 48'h2038, 0, '0, '0); chk("pipe_qready3", 512'(s_rsp_n.q_ready), 512'd1);
        drain();

        // Full: four outstanding, fifth blocked even with a response in that cycle.
        lat = 1000;
        for (int i = 0; i < 4; i++) begin
            tick(1, 48'h3000 + 48'(8 * (i + 2)), 0, '0, '0);
            chk("full_fill_qready", 512'(s_rsp_n.q_ready), 512'd1);
        end
        pend[0].due = cyc;
        tick(1, 48'h3030, 0, '0, '0);
        chk("full_qready", 512'(s_rsp_n.q_ready), 512'd0);
        chk("full_wvalid", 512'(s_req_w.q_valid), 512'd0);
        tick(1, 48'h3030, 0, '0, '0);
        chk("full_after_pop_qready", 512'(s_rsp_n.q_ready), 512'd1);
        chk("full_after_pop_wvalid", 512'(s_req_w.q_valid), 512'd1);
        drain();

        // Steady push/pop at count 2 over ten transactions.
        lat = 2;
        for (int i = 0; i < 10; i++) begin
            tick(1, 48'h4000 + 48'(8 * ((i * 3) % 8)), 0, '0, '0);
            chk("pp_qready", 512'(s_rsp_n.q_ready), 512'd1);
        end
        drain();

        // Reset with three outstanding; old offsets must be gone.
        lat = 1000;
        for (int i = 0; i < 3; i++) tick(1, 48'h5008, 0, '0, '0);
        rst = 1'b1;
        pend.delete();
        exp_q.delete();
        rsp_w.p_valid = 1'b0;
        req_n.q_valid = 1'b1;
        #1;
        chk("midrst_wvalid", 512'(req_w.q_valid), 512'd1);
        req_n.q_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1, 48'h6020, 0, '0, '0); chk("postrst_qready0", 512'(s_rsp_n.q_ready), 512'd1);
        tick(1, 48'h6008, 0, '0, '0); chk("postrst_qready1", 512'(s_rsp_n.q_ready), 512'd1);
        tick(1, 48'h6010, 0, '0, '0); chk("postrst_qready2", 512'(s_rsp_n.q_ready), 512'd1);
        tick(1, 48'h6018, 0, '0, '0); chk("postrst_qready3", 512'(s_rsp_n.q_ready), 512'd1);
        tick(1, 48'h6000, 0, '0, '0); chk("postrst_full", 512'(s_rsp_n.q_ready), 512'd0);
        pend[0].due = cyc;
        tick(0, '0, 0, '0, '0);
        chk("postrst_lane4", s_rsp_n.p.data, 512'(lane_val(id_ctr - 4, 3'd4)));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
